// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unknown opcodes trap instead of running as a NOP).
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func,
    input  logic       func1,
    input  logic       br_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] alu_mode,
    output logic       alu_alt,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_op;
    logic [2:0] r_func;
    logic       r_func1;

    logic       w_a_sel;
    logic       w_b_sel;
    logic [2:0] w_mode;
    logic       w_alt;

`ifdef ILLEGAL_OP_TRAP_EN
    function automatic logic is_known(input logic [6:0] o);
        case (o)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_B,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_known = 1'b1;
            default:                           is_known = 1'b0;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_func  <= '0;
            r_func1 <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_op    <= op;
            r_func  <= func;
            r_func1 <= func1;
        end
    end

    // ALU operand/mode selects are a function of the latched instruction only,
    // so they stay stable from EXEC through MEM and WB.
    always_comb begin
        w_a_sel = 1'b0;
        w_b_sel = 1'b0;
        w_mode  = '0;
        w_alt   = 1'b0;
        case (r_op)
            OP_R: begin
                w_mode = r_func;
                w_alt  = r_func1;
            end
            OP_I: begin
                w_b_sel = 1'b1;
                w_mode  = r_func;
                w_alt   = (r_func == 3'b101) ? r_func1 : 1'b0;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                w_b_sel = 1'b1;
            end
            OP_AUIPC, OP_JAL, OP_B: begin
                w_a_sel = 1'b1;
                w_b_sel = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_mode  = '0;
        alu_alt   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = '0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
                if (imem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
`ifdef ILLEGAL_OP_TRAP_EN
                w_next = is_known(op) ? S_EXEC : S_TRAP;
`else
                w_next = S_EXEC;
`endif
            end
            S_EXEC: begin
                alu_a_sel = w_a_sel;
                alu_b_sel = w_b_sel;
                alu_mode  = w_mode;
                alu_alt   = w_alt;
                case (r_op)
                    OP_R, OP_I, OP_JALR, OP_AUIPC, OP_JAL, OP_LUI: w_next = S_WB;
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_B: begin
                        pc_we  = 1'b1;
                        pc_src = br_taken;
                        w_next = S_FETCH;
                    end
                    default: begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                alu_a_sel = w_a_sel;
                alu_b_sel = w_b_sel;
                alu_mode  = w_mode;
                alu_alt   = w_alt;
                dmem_req  = 1'b1;
                dmem_we   = (r_op == OP_STORE);
                if (dmem_ready) begin
                    if (r_op == OP_STORE) begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_a_sel = w_a_sel;
                alu_b_sel = w_b_sel;
                alu_mode  = w_mode;
                alu_alt   = w_alt;
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                pc_src    = (r_op == OP_JAL) || (r_op == OP_JALR);
                case (r_op)
                    OP_LOAD:         wb_sel = 2'd1;
                    OP_JAL, OP_JALR: wb_sel = 2'd2;
                    OP_LUI:          wb_sel = 2'd3;
                    default:         wb_sel = 2'd0;
                endcase
                w_next = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    assign state = r_state;

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal = (r_state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction behaviour checked against a class table.
// Honours ILLEGAL_OP_TRAP_EN the same way the design does.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] func = '0;
    logic       func1 = 1'b0;
    logic       br_taken = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src;
    logic       alu_a_sel, alu_b_sel, alu_alt, reg_we, illegal;
    logic [2:0] alu_mode, state;
    logic [1:0] wb_sel;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_B,
                                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    typedef struct {
        int cyc;
        int regwe;
        int wbsel;
        int pcsrc;
        int chk_alu;
        int asel;
        int bsel;
        int mode;
        int alt;
        int dreq;
        int dwe;
    } exp_t;

    multicycle_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .func       (func),
        .func1      (func1),
        .br_taken   (br_taken),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .alu_mode   (alu_mode),
        .alu_alt    (alu_alt),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, alu_a_sel,
                     alu_b_sel, alu_mode, alu_alt, reg_we, wb_sel});
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        foreach (legal_ops[k]) if (legal_ops[k] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Instruction-class table: cycle cost, writeback and PC behaviour, operand selects.
    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f, input logic f1,
                                   input logic br, input int iw, input int dw);
        exp_t e;
        int   base = 4;
        bit   mem = 0, st = 0;
        e = '{cyc: 0, regwe: 0, wbsel: 0, pcsrc: 0, chk_alu: 1, asel: 0, bsel: 0,
              mode: 0, alt: 0, dreq: 0, dwe: 0};
        case (o)
            OP_R:     begin e.regwe = 1; e.mode = int'(f); e.alt = int'(f1); end
            OP_I:     begin e.regwe = 1; e.bsel = 1; e.mode = int'(f);
                            e.alt = (f == 3'b101) ? int'(f1) : 0; end
            OP_LOAD:  begin base = 5; mem = 1; e.regwe = 1; e.wbsel = 1; e.bsel = 1; end
            OP_STORE: begin mem = 1; st = 1; e.bsel = 1; end
            OP_JALR:  begin e.regwe = 1; e.wbsel = 2; e.pcsrc = 1; e.bsel = 1; end
            OP_JAL:   begin e.regwe = 1; e.wbsel = 2; e.pcsrc = 1; e.asel = 1; e.bsel = 1; end
            OP_AUIPC: begin e.regwe = 1; e.asel = 1; e.bsel = 1; end
            OP_LUI:   begin e.regwe = 1; e.wbsel = 3; e.chk_alu = 0; end
            OP_B:     begin base = 3; e.pcsrc = int'(br); e.asel = 1; e.bsel = 1; end
            default:  begin base = 3; e.chk_alu = 0; end
        endcase
        e.cyc  = base + iw + (mem ? dw : 0);
        e.dreq = mem ? dw + 1 : 0;
        e.dwe  = st ? dw + 1 : 0;
        return e;
    endfunction

    // Entered at a falling edge with the FSM in FETCH; returns at the falling edge of the next FETCH.
    task automatic run_instr(input int idx, input logic [6:0] iop, input logic [2:0] ifn,
                             input logic if1, input logic br, input int iw, input int dw);
        exp_t  e;
        string t;
        int cyc = 0, fcnt = 0, dcnt = 0, n_pcwe = 0, pcs = -1, n_regwe = 0, wbs = -1;
        int wb_a = -1, wb_b = -1, ex_a = -1, ex_b = -1, ex_mode = -1, ex_alt = -1;
        int n_dreq = 0, n_dwe = 0, n_ireq = 0, n_irwe = 0, n_both = 0, n_ill = 0;
        bit left = 0;
        e = model(iop, ifn, if1, br, iw, dw);
        br_taken = br;
        while (cyc < 64) begin
            if (state == 3'd2) begin
                op = iop; func = ifn; func1 = if1;
            end else begin
                op = 7'($urandom_range(127)); func = 3'($urandom_range(7));
                func1 = 1'($urandom_range(1));
            end
            imem_ready = (state == 3'd1) ? (fcnt == iw) : 1'($urandom_range(1));
            dmem_ready = (state == 3'd4) ? (dcnt == dw) : 1'($urandom_range(1));
            #1;
            cyc++;
            if (state != 3'd1) left = 1;
            if (state == 3'd1) fcnt++;
            if (state == 3'd4) dcnt++;
            if (pc_we) begin n_pcwe++; pcs = int'(pc_src); end
            if (reg_we) begin
                n_regwe++; wbs = int'(wb_sel); wb_a = int'(alu_a_sel); wb_b = int'(alu_b_sel);
            end
            if (state == 3'd3) begin
                ex_a = int'(alu_a_sel); ex_b = int'(alu_b_sel);
                ex_mode = int'(alu_mode); ex_alt = int'(alu_alt);
            end
            if (dmem_req) n_dreq++;
            if (dmem_req && dmem_we) n_dwe++;
            if (imem_req) n_ireq++;
            if (ir_we) n_irwe++;
            if (imem_req && dmem_req) n_both++;
            if (illegal) n_ill++;
            @(negedge clk);
            if (left && state == 3'd1) break;
        end
        t = $sformatf("i%0d op=%b", idx, iop);
        check_eq({t, " cycles"}, cyc, e.cyc);
        check_eq({t, " pc_we count"}, n_pcwe, 1);
        check_eq({t, " pc_src"}, pcs, e.pcsrc);
        check_eq({t, " reg_we count"}, n_regwe, e.regwe);
        if (e.regwe != 0) check_eq({t, " wb_sel"}, wbs, e.wbsel);
        if (e.chk_alu != 0) begin
            check_eq({t, " exec a_sel"}, ex_a, e.asel);
            check_eq({t, " exec b_sel"}, ex_b, e.bsel);
            check_eq({t, " exec alu_mode"}, ex_mode, e.mode);
            check_eq({t, " exec alu_alt"}, ex_alt, e.alt);
            if (e.regwe != 0) begin
                check_eq({t, " wb a_sel"}, wb_a, e.asel);
                check_eq({t, " wb b_sel"}, wb_b, e.bsel);
            end
        end
        check_eq({t, " dmem_req cycles"}, n_dreq, e.dreq);
        check_eq({t, " dmem_we cycles"}, n_dwe, e.dwe);
        check_eq({t, " imem_req cycles"}, n_ireq, iw + 1);
        check_eq({t, " ir_we count"}, n_irwe, 1);
        check_eq({t, " both requests"}, n_both, 0);
        check_eq({t, " illegal"}, n_ill, 0);
    endtask

    initial begin
        logic [6:0] rop;
        #1 rst = 1'b1;
        #2;
        check_eq("async reset state", int'(state), 0);
        check_eq("async reset outputs", all_outs(), 0);
        check_eq("async reset illegal", int'(illegal), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle state", int'(state), 0);
        check_eq("idle outputs", all_outs(), 0);
        @(negedge clk);
        check_eq("fetch after idle", int'(state), 1);

        run_instr(0, OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(1, OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr(2, OP_B, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(3, OP_B, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(4, OP_JALR, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(5, OP_STORE, 3'b010, 1'b0, 1'b0, 2, 1);
        run_instr(6, OP_I, 3'b101, 1'b1, 1'b0, 1, 0);

        // Reset dropped into the middle of a data-memory wait.
        imem_ready = 1'b1; #1;
        @(negedge clk);
        op = OP_LOAD; func = 3'b010; func1 = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        op = '0;
        @(negedge clk);
        dmem_ready = 1'b0; #1;
        check_eq("mid-mem state", int'(state), 4);
        check_eq("mid-mem dmem_req", int'(dmem_req), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mem reset state", int'(state), 0);
        check_eq("mem reset dmem_req", int'(dmem_req), 0);
        check_eq("mem reset outputs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post-reset idle", int'(state), 0);
        @(negedge clk);
        check_eq("post-reset fetch", int'(state), 1);

        for (int i = 0; i < 60; i++) begin
            rop = legal_ops[$urandom_range(8)];
`ifndef ILLEGAL_OP_TRAP_EN
            if ($urandom_range(9) == 0) begin
                rop = 7'($urandom_range(127));
                while (is_legal(rop)) rop = 7'($urandom_range(127));
            end
`endif
            run_instr(100 + i, rop, 3'($urandom_range(7)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), $urandom_range(3), $urandom_range(3));
        end

`ifdef ILLEGAL_OP_TRAP_EN
        imem_ready = 1'b1; #1;
        @(negedge clk);
        op = 7'b1111111; imem_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            imem_ready = 1'($urandom_range(1)); dmem_ready = 1'($urandom_range(1));
            op = OP_R;
            #1;
            check_eq($sformatf("trap state c%0d", c), int'(state), 6);
            check_eq($sformatf("trap illegal c%0d", c), int'(illegal), 1);
            check_eq($sformatf("trap outputs c%0d", c), all_outs(), 0);
            @(negedge clk);
        end
`else
        run_instr(200, 7'b1111111, 3'b000, 1'b0, 1'b1, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
